// File: rtl/move_sequencer_if.sv
// rtl/move_sequencer_if.sv - move request and board RAM bundle for move_sequencer
interface move_sequencer_if;
  logic       move_valid;
  logic       move_ready;
  logic [2:0] move_x;
  logic [2:0] move_y;
  logic       player;
  logic [5:0] mem_addr;
  logic [1:0] mem_rd_data;
  logic       mem_wr_en;
  logic [1:0] mem_wr_data;
  logic       turn_en;
  logic       move_done;
  logic       move_illegal;
  logic [5:0] flip_count;

  // master: requester plus board RAM; slave: the sequencer itself
  modport master (
    output move_valid, move_x, move_y, player, mem_rd_data,
    input  move_ready, mem_addr, mem_wr_en, mem_wr_data,
    input  turn_en, move_done, move_illegal, flip_count
  );

  modport slave (
    input  move_valid, move_x, move_y, player, mem_rd_data,
    output move_ready, mem_addr, mem_wr_en, mem_wr_data,
    output turn_en, move_done, move_illegal, flip_count
  );
endinterface

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - Reversi move checker: scans 8 directions, flips runs, places piece
module move_sequencer #(
  parameter logic [1:0] BLACK_CODE = 2'b01,
  parameter logic [1:0] WHITE_CODE = 2'b10
) (
  input logic             clk,
  input logic             resetn,
  move_sequencer_if.slave bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CHK_RD   = 4'd1;
  localparam logic [3:0] CHK_EV   = 4'd2;
  localparam logic [3:0] SCAN_RD  = 4'd3;
  localparam logic [3:0] SCAN_EV  = 4'd4;
  localparam logic [3:0] FLIP     = 4'd5;
  localparam logic [3:0] NEXT_DIR = 4'd6;
  localparam logic [3:0] PLACE    = 4'd7;
  localparam logic [3:0] REJECT   = 4'd8;

  // Direction order N, NE, E, SE, S, SW, W, NW; N decreases y
  function automatic logic [3:0] dir_dx(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: dir_dx = 4'b0001;
      3'd5, 3'd6, 3'd7: dir_dx = 4'b1111;
      default:          dir_dx = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] dir_dy(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: dir_dy = 4'b1111;
      3'd3, 3'd4, 3'd5: dir_dy = 4'b0001;
      default:          dir_dy = 4'b0000;
    endcase
  endfunction

  logic [3:0] state_q, state_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic       player_q, player_d;
  logic [2:0] dir_q, dir_d;
  logic [3:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;
  logic [2:0] run_q, run_d;
  logic [5:0] total_q, total_d;
  logic [5:0] flip_count_q, flip_count_d;

  logic [1:0] own_code;
  logic [1:0] opp_code;
  logic [2:0] dir_nxt;
  logic       off_board;
  logic       target_occupied;

  assign own_code        = player_q ? BLACK_CODE : WHITE_CODE;
  assign opp_code        = player_q ? WHITE_CODE : BLACK_CODE;
  assign dir_nxt         = dir_q + 3'd1;
  // Stepping past 7 gives 8, past 0 gives 15: bit 3 flags both
  assign off_board       = cx_q[3] | cy_q[3];
  assign target_occupied = (bus.mem_rd_data == BLACK_CODE) || (bus.mem_rd_data == WHITE_CODE);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    player_d     = player_q;
    dir_d        = dir_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    run_d        = run_q;
    total_d      = total_q;
    flip_count_d = flip_count_q;
    case (state_q)
      IDLE: begin
        if (bus.move_valid) begin
          x_d      = bus.move_x;
          y_d      = bus.move_y;
          player_d = bus.player;
          total_d  = 6'd0;
          state_d  = CHK_RD;
        end
      end
      CHK_RD: state_d = CHK_EV;
      CHK_EV: begin
        if (target_occupied) begin
          state_d = REJECT;
        end else begin
          dir_d   = 3'd0;
          cx_d    = {1'b0, x_q} + dir_dx(3'd0);
          cy_d    = {1'b0, y_q} + dir_dy(3'd0);
          run_d   = 3'd0;
          state_d = SCAN_RD;
        end
      end
      SCAN_RD: state_d = off_board ? NEXT_DIR : SCAN_EV;
      SCAN_EV: begin
        if (bus.mem_rd_data == opp_code) begin
          run_d   = run_q + 3'd1;
          cx_d    = cx_q + dir_dx(dir_q);
          cy_d    = cy_q + dir_dy(dir_q);
          state_d = SCAN_RD;
        end else if (bus.mem_rd_data == own_code && run_q != 3'd0) begin
          // run_q now counts cells left to flip, cursor rewinds to target+dir
          total_d = total_q + {3'b000, run_q};
          cx_d    = {1'b0, x_q} + dir_dx(dir_q);
          cy_d    = {1'b0, y_q} + dir_dy(dir_q);
          state_d = FLIP;
        end else begin
          state_d = NEXT_DIR;
        end
      end
      FLIP: begin
        run_d = run_q - 3'd1;
        cx_d  = cx_q + dir_dx(dir_q);
        cy_d  = cy_q + dir_dy(dir_q);
        if (run_q == 3'd1) state_d = NEXT_DIR;
      end
      NEXT_DIR: begin
        if (dir_q == 3'd7) begin
          state_d = (total_q != 6'd0) ? PLACE : REJECT;
        end else begin
          dir_d   = dir_nxt;
          cx_d    = {1'b0, x_q} + dir_dx(dir_nxt);
          cy_d    = {1'b0, y_q} + dir_dy(dir_nxt);
          run_d   = 3'd0;
          state_d = SCAN_RD;
        end
      end
      PLACE: begin
        flip_count_d = total_q;
        state_d      = IDLE;
      end
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      x_q          <= 3'd0;
      y_q          <= 3'd0;
      player_q     <= 1'b0;
      dir_q        <= 3'd0;
      cx_q         <= 4'd0;
      cy_q         <= 4'd0;
      run_q        <= 3'd0;
      total_q      <= 6'd0;
      flip_count_q <= 6'd0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      player_q     <= player_d;
      dir_q        <= dir_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      run_q        <= run_d;
      total_q      <= total_d;
      flip_count_q <= flip_count_d;
    end
  end

  always_comb begin
    bus.mem_addr = 6'd0;
    case (state_q)
      CHK_RD, PLACE: bus.mem_addr = {y_q, x_q};
      SCAN_RD:       bus.mem_addr = off_board ? 6'd0 : {cy_q[2:0], cx_q[2:0]};
      FLIP:          bus.mem_addr = {cy_q[2:0], cx_q[2:0]};
      default:       bus.mem_addr = 6'd0;
    endcase
  end

  assign bus.move_ready   = (state_q == IDLE);
  assign bus.mem_wr_en    = (state_q == FLIP) || (state_q == PLACE);
  assign bus.mem_wr_data  = bus.mem_wr_en ? own_code : 2'b00;
  assign bus.move_done    = (state_q == PLACE);
  assign bus.turn_en      = (state_q == PLACE);
  assign bus.move_illegal = (state_q == REJECT);
  assign bus.flip_count   = flip_count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - directed table-driven bench for move_sequencer with board RAM model
module tb_move_sequencer;

  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic clk;
  logic resetn;
  logic load;
  logic [1:0] mem [64];
  logic [1:0] board_img [64];

  move_sequencer_if bus ();

  move_sequencer #(.BLACK_CODE(2'b01), .WHITE_CODE(2'b10)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read board RAM: data valid the cycle after the address
  always @(posedge clk) begin
    if (load) begin
      mem <= board_img;
    end else begin
      bus.mem_rd_data <= mem[bus.mem_addr];
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    end
  end

  typedef struct {
    int setup;
    int x;
    int y;
    int pl;
    int legal;
    int flips;
    int writes;
    int first_wr;
    int exp_target;
  } vec_t;

  vec_t vecs [9];
  int checks = 0;
  int errors = 0;
  int fc_exp = 0;
  int n_wr, n_turn, n_done, n_ill, n_skew, first_wr, cycles, timed_out;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_board(input int id);
    for (int i = 0; i < 64; i++) board_img[i] = 2'b00;
    case (id)
      1: begin
        board_img[27] = W; board_img[36] = W;
        board_img[28] = B; board_img[35] = B;
      end
      2: begin
        for (int i = 1; i <= 6; i++) board_img[i] = W;
        board_img[7] = B;
      end
      3: begin
        board_img[27] = W; board_img[26] = W; board_img[19] = W;
        board_img[36] = B; board_img[34] = B; board_img[20] = B;
      end
      4: begin
        for (int yy = 1; yy <= 6; yy++) board_img[yy*8+7] = B;
        board_img[7] = W;
      end
      5: for (int i = 1; i <= 7; i++) board_img[i] = W;
      default: ;
    endcase
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic do_move(input int x, input int y, input int pl);
    @(negedge clk);
    bus.move_x     = x[2:0];
    bus.move_y     = y[2:0];
    bus.player     = pl[0];
    bus.move_valid = 1'b1;
    @(posedge clk);
    #1 bus.move_valid = 1'b0;
    n_wr = 0; n_turn = 0; n_done = 0; n_ill = 0; n_skew = 0;
    first_wr = -1; cycles = 0; timed_out = 1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        if (n_wr == 0) first_wr = int'(bus.mem_addr);
        n_wr++;
      end
      if (bus.turn_en) n_turn++;
      if (bus.move_done) n_done++;
      if (bus.move_illegal) n_ill++;
      if (bus.turn_en != bus.move_done) n_skew++;
      if (bus.move_done || bus.move_illegal) begin
        cycles = c;
        timed_out = 0;
        break;
      end
    end
    check("move_timeout", timed_out, 0);
  endtask

  initial begin
    int acc;
    int tgt;
    int own;
    resetn = 1'b0;
    load = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_x = 3'd0;
    bus.move_y = 3'd0;
    bus.player = 1'b0;

    //                setup x  y  pl legal flips writes first target
    vecs[0] = '{1, 3, 2, 1, 1, 1, 2, 27, 1};
    vecs[1] = '{1, 3, 3, 1, 0, 0, 0, -1, 2};
    vecs[2] = '{1, 0, 0, 1, 0, 0, 0, -1, 0};
    vecs[3] = '{1, 4, 2, 0, 1, 1, 2, 28, 2};
    vecs[4] = '{2, 0, 0, 1, 1, 6, 7, 1, 1};
    vecs[5] = '{1, 3, 2, 0, 0, 0, 0, -1, 0};
    vecs[6] = '{3, 2, 2, 1, 1, 3, 4, 19, 1};
    vecs[7] = '{4, 7, 7, 0, 1, 6, 7, 55, 2};
    vecs[8] = '{5, 0, 0, 1, 0, 0, 0, -1, 0};

    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.move_ready), 1);
    check("rst_wr_en", int'(bus.mem_wr_en), 0);
    check("rst_turn_en", int'(bus.turn_en), 0);
    check("rst_done", int'(bus.move_done), 0);
    check("rst_illegal", int'(bus.move_illegal), 0);
    check("rst_flip_count", int'(bus.flip_count), 0);
    check("rst_addr", int'(bus.mem_addr), 0);
    resetn = 1'b1;

    for (int v = 0; v < 9; v++) begin
      set_board(vecs[v].setup);
      do_move(vecs[v].x, vecs[v].y, vecs[v].pl);
      if (vecs[v].legal != 0) fc_exp = vecs[v].flips;
      check($sformatf("v%0d_done", v), n_done, vecs[v].legal);
      check($sformatf("v%0d_illegal", v), n_ill, 1 - vecs[v].legal);
      check($sformatf("v%0d_turn_en", v), n_turn, vecs[v].legal);
      check($sformatf("v%0d_turn_skew", v), n_skew, 0);
      check($sformatf("v%0d_writes", v), n_wr, vecs[v].writes);
      check($sformatf("v%0d_first_wr", v), first_wr, vecs[v].first_wr);
      @(negedge clk);
      check($sformatf("v%0d_flip_count", v), int'(bus.flip_count), fc_exp);
      tgt = vecs[v].y * 8 + vecs[v].x;
      own = (vecs[v].pl != 0) ? 1 : 2;
      check($sformatf("v%0d_target_cell", v), int'(mem[tgt]), vecs[v].exp_target);
      if (vecs[v].legal != 0)
        check($sformatf("v%0d_flipped_cell", v), int'(mem[vecs[v].first_wr]), own);
    end

    // Occupied target is rejected right after the target evaluation
    set_board(1);
    do_move(3, 3, 1);
    check("occ_latency", cycles, 3);
    check("occ_writes", n_wr, 0);

    // move_valid held high across a busy move is taken only once
    set_board(1);
    acc = 0; n_done = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      bus.move_x = 3'd3; bus.move_y = 3'd2; bus.player = 1'b1;
      bus.move_valid = (c < 10);
      if (bus.move_ready && bus.move_valid) acc++;
      if (bus.move_done) n_done++;
    end
    bus.move_valid = 1'b0;
    check("busy_accepts", acc, 1);
    check("busy_done", n_done, 1);
    check("busy_flip_count", int'(bus.flip_count), 1);

    // Reset mid-FLIP: outputs go to reset values at once, written cells stay
    set_board(2);
    @(negedge clk);
    bus.move_x = 3'd0; bus.move_y = 3'd0; bus.player = 1'b1;
    bus.move_valid = 1'b1;
    @(posedge clk);
    #1 bus.move_valid = 1'b0;
    timed_out = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        timed_out = 0;
        break;
      end
    end
    check("flip_reached", timed_out, 0);
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_ready", int'(bus.move_ready), 1);
    check("midrst_wr_en", int'(bus.mem_wr_en), 0);
    check("midrst_turn_en", int'(bus.turn_en), 0);
    check("midrst_done", int'(bus.move_done), 0);
    check("midrst_illegal", int'(bus.move_illegal), 0);
    check("midrst_flip_count", int'(bus.flip_count), 0);
    check("midrst_addr", int'(bus.mem_addr), 0);
    check("midrst_cell1", int'(mem[1]), 1);
    check("midrst_cell2", int'(mem[2]), 1);
    check("midrst_cell3", int'(mem[3]), 2);
    check("midrst_target", int'(mem[0]), 0);
    @(negedge clk);
    resetn = 1'b1;

    set_board(1);
    do_move(3, 2, 1);
    check("post_rst_done", n_done, 1);
    check("post_rst_writes", n_wr, 2);
    @(negedge clk);
    check("post_rst_flip_count", int'(bus.flip_count), 1);
    check("post_rst_cell27", int'(mem[27]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
